uart_tx_arbiter: RTL and testbench

Shares the single UART transmit channel (`DataIn`/`DataInValid`/`DataInReady` of the UART block) between `NumPorts` byte-stream requesters. Arbitration is round-robin at message granularity. A granted port owns the transmitter until it sends a byte flagged `Last`, reaches the `MaxBurst` byte cap, or stalls for `IdleTimeout` cycles. It sits between on-chip producers (CPU console, debug/trace streams) and the UART, so messages from different sources never interleave byte-by-byte.

---
 rtl/uart_tx_arbiter_if.sv | 24 ++
 rtl/uart_tx_arbiter.sv | 126 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester and UART transmit handshake bundle for uart_tx_arbiter
interface uart_tx_arbiter_if #(
   parameter int NumPorts = 4
);
   logic [8*NumPorts-1:0] ReqData;
   logic [NumPorts-1:0]   ReqValid;
   logic [NumPorts-1:0]   ReqLast;
   logic [NumPorts-1:0]   ReqReady;
   logic [7:0]            UartDataIn;
   logic                  UartDataInValid;
   logic                  UartDataInReady;
   logic [NumPorts-1:0]   Grant;
   logic                  Busy;

   modport master (
      output ReqData, ReqValid, ReqLast, UartDataInReady,
      input  ReqReady, UartDataIn, UartDataInValid, Grant, Busy
   );

   modport slave (
      input  ReqData, ReqValid, ReqLast, UartDataInReady,
      output ReqReady, UartDataIn, UartDataInValid, Grant, Busy
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - message-granular round-robin sharing of one UART transmit channel
// A grant ends on a Last byte, the MaxBurst cap, or IdleTimeout owner-idle cycles.
module uart_tx_arbiter #(
   parameter int NumPorts    = 4,
   parameter int MaxBurst    = 16,
   parameter int IdleTimeout = 1024
) (
   input logic              Clock,
   input logic              Reset,
   uart_tx_arbiter_if.slave bus
);
   localparam int OW = $clog2(NumPorts);
   localparam int BW = $clog2(MaxBurst + 1);
   localparam int IW = $clog2(IdleTimeout + 1);
   localparam logic [OW-1:0] LastPort  = OW'(NumPorts - 1);
   localparam logic [BW-1:0] BurstLast = BW'(MaxBurst - 1);
   localparam logic [IW-1:0] IdleLast  = IW'(IdleTimeout - 1);

   typedef enum logic {
      IDLE,
      LOCKED
   } state_t;

   state_t        state, state_next;
   logic [OW-1:0] owner, owner_next;
   logic [OW-1:0] pointer, pointer_next;
   logic [BW-1:0] byte_count, byte_count_next;
   logic [IW-1:0] idle_count, idle_count_next;
   logic [OW-1:0] pick;
   logic          found;
   logic          owner_valid;
   logic          transfer;
   logic          release_now;

   // Scan downward so the last hit wins: that is the first valid port at or after pointer.
   always_comb begin : arbitrate
      int            idx;
      logic [OW-1:0] sel;
      pick  = '0;
      found = 1'b0;
      idx   = 0;
      sel   = '0;
      for (int i = NumPorts - 1; i >= 0; i--) begin
         idx = int'(pointer) + i;
         if (idx >= NumPorts) begin
            idx = idx - NumPorts;
         end
         sel = OW'(idx);
         if (bus.ReqValid[sel]) begin
            pick  = sel;
            found = 1'b1;
         end
      end
   end

   assign owner_valid = bus.ReqValid[owner];
   assign transfer    = (state == LOCKED) && owner_valid && bus.UartDataInReady;

   always_comb begin : next_state
      state_next      = state;
      owner_next      = owner;
      pointer_next    = pointer;
      byte_count_next = byte_count;
      idle_count_next = idle_count;
      release_now     = 1'b0;
      case (state)
         IDLE: begin
            if (found) begin
               state_next      = LOCKED;
               owner_next      = pick;
               byte_count_next = '0;
               idle_count_next = '0;
            end
         end
         LOCKED: begin
            if (transfer) begin
               byte_count_next = byte_count + 1'b1;
               idle_count_next = '0;
               release_now     = bus.ReqLast[owner] || (byte_count == BurstLast);
            end else if (!owner_valid) begin
               idle_count_next = idle_count + 1'b1;
               release_now     = (idle_count == IdleLast);
            end else begin
               // Owner is offering but the UART stalls: not owner idleness.
               idle_count_next = '0;
            end
            if (release_now) begin
               state_next   = IDLE;
               pointer_next = (owner == LastPort) ? '0 : owner + 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin : outputs
      bus.Grant           = '0;
      bus.ReqReady        = '0;
      bus.UartDataIn      = '0;
      bus.UartDataInValid = 1'b0;
      bus.Busy            = 1'b0;
      if (state == LOCKED) begin
         bus.Grant[owner]    = 1'b1;
         bus.ReqReady[owner] = bus.UartDataInReady;
         bus.UartDataIn      = bus.ReqData[{owner, 3'b000} +: 8];
         bus.UartDataInValid = owner_valid;
         bus.Busy            = 1'b1;
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state      <= IDLE;
         owner      <= '0;
         pointer    <= '0;
         byte_count <= '0;
         idle_count <= '0;
      end else begin
         state      <= state_next;
         owner      <= owner_next;
         pointer    <= pointer_next;
         byte_count <= byte_count_next;
         idle_count <= idle_count_next;
      end
   end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed vector table plus multi-cycle sequences for uart_tx_arbiter
module tb_uart_tx_arbiter;
   logic Clock = 1'b0;
   logic Reset;

   uart_tx_arbiter_if #(.NumPorts(4)) bus ();

   uart_tx_arbiter #(
      .NumPorts(4),
      .MaxBurst(4),
      .IdleTimeout(8)
   ) dut (
      .Clock(Clock),
      .Reset(Reset),
      .bus(bus)
   );

   always #5 Clock = ~Clock;

   typedef struct {
      logic        rst;
      logic [3:0]  valid;
      logic [3:0]  last;
      logic [31:0] data;
      logic        rdy;
      logic [3:0]  grant;
      logic        busy;
      logic        uvalid;
      logic [7:0]  udata;
      logic [3:0]  rready;
   } vec_t;

   vec_t vecs[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   logic [8:0] src [4][32];
   int         head [4];
   int         tail [4];
   logic [9:0] xlog [64];
   int         nlog;
   logic [3:0] hist [128];
   int         ncyc;

   function automatic vec_t mk(input logic rst, input logic [3:0] valid, input logic [3:0] last,
                               input logic [31:0] data, input logic rdy, input logic [3:0] grant,
                               input logic busy, input logic uvalid, input logic [7:0] udata,
                               input logic [3:0] rready);
      vec_t v;
      v.rst = rst;     v.valid = valid;   v.last = last;   v.data = data;   v.rdy = rdy;
      v.grant = grant; v.busy = busy;     v.uvalid = uvalid; v.udata = udata; v.rready = rready;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic apply(input vec_t v, input int k);
      @(negedge Clock);
      Reset               = v.rst;
      bus.ReqValid        = v.valid;
      bus.ReqLast         = v.last;
      bus.ReqData         = v.data;
      bus.UartDataInReady = v.rdy;
      #1;
      check($sformatf("v%0d grant", k),  32'(bus.Grant),           32'(v.grant));
      check($sformatf("v%0d busy", k),   32'(bus.Busy),            32'(v.busy));
      check($sformatf("v%0d uvalid", k), 32'(bus.UartDataInValid), 32'(v.uvalid));
      check($sformatf("v%0d udata", k),  32'(bus.UartDataIn),      32'(v.udata));
      check($sformatf("v%0d rready", k), 32'(bus.ReqReady),        32'(v.rready));
   endtask

   task automatic clear_src();
      for (int i = 0; i < 4; i++) begin
         head[i] = 0;
         tail[i] = 0;
      end
      nlog = 0;
      ncyc = 0;
   endtask

   task automatic push(input int p, input logic [7:0] b, input logic l);
      src[p][tail[p]] = {l, b};
      tail[p]++;
   endtask

   // One cycle of the per-port byte sources; records grant history and accepted bytes.
   task automatic run(input logic rdy, input logic rst);
      logic [3:0]  v;
      logic [3:0]  l;
      logic [31:0] d;
      @(negedge Clock);
      v = '0;
      l = '0;
      d = '0;
      for (int i = 0; i < 4; i++) begin
         if (head[i] < tail[i]) begin
            v[i]         = 1'b1;
            l[i]         = src[i][head[i]][8];
            d[i*8 +: 8]  = src[i][head[i]][7:0];
         end
      end
      Reset               = rst;
      bus.ReqValid        = v;
      bus.ReqLast         = l;
      bus.ReqData         = d;
      bus.UartDataInReady = rdy;
      #1;
      if (ncyc < 128) begin
         hist[ncyc] = bus.Grant;
      end
      ncyc++;
      for (int i = 0; i < 4; i++) begin
         if (v[i] && bus.ReqReady[i]) begin
            if (nlog < 64) begin
               xlog[nlog] = {2'(i), d[i*8 +: 8]};
            end
            nlog++;
            head[i]++;
         end
      end
   endtask

   task automatic check_log(input string tag, input int k, input logic [1:0] p, input logic [7:0] b);
      check($sformatf("%s log%0d", tag, k), 32'(xlog[k]), 32'({p, b}));
   endtask

   task automatic check_hist(input string tag, input int k, input logic [3:0] g);
      check($sformatf("%s grant@%0d", tag, k), 32'(hist[k]), 32'(g));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] exp_burst [12];
      logic [3:0] exp_tmo   [13];

      // Single message on port 2, then pointer=3 arbitration, then contention from reset.
      vecs.push_back(mk(0, 4'b0100, 4'b0000, 32'h0041_0000, 1, 4'b0000, 0, 0, 8'h00, 4'b0000));
      vecs.push_back(mk(0, 4'b0100, 4'b0000, 32'h0041_0000, 1, 4'b0100, 1, 1, 8'h41, 4'b0100));
      vecs.push_back(mk(0, 4'b0100, 4'b0000, 32'h0042_0000, 1, 4'b0100, 1, 1, 8'h42, 4'b0100));
      vecs.push_back(mk(0, 4'b0100, 4'b0100, 32'h0043_0000, 1, 4'b0100, 1, 1, 8'h43, 4'b0100));
      vecs.push_back(mk(0, 4'b0000, 4'b0000, 32'h0000_0000, 1, 4'b0000, 0, 0, 8'h00, 4'b0000));
      vecs.push_back(mk(0, 4'b1001, 4'b1001, 32'h3300_0030, 1, 4'b0000, 0, 0, 8'h00, 4'b0000));
      vecs.push_back(mk(0, 4'b1001, 4'b1001, 32'h3300_0030, 1, 4'b1000, 1, 1, 8'h33, 4'b1000));
      vecs.push_back(mk(0, 4'b0001, 4'b0001, 32'h0000_0030, 1, 4'b0000, 0, 0, 8'h00, 4'b0000));
      vecs.push_back(mk(0, 4'b0001, 4'b0001, 32'h0000_0030, 1, 4'b0001, 1, 1, 8'h30, 4'b0001));
      vecs.push_back(mk(0, 4'b0000, 4'b0000, 32'h0000_0000, 1, 4'b0000, 0, 0, 8'h00, 4'b0000));
      vecs.push_back(mk(1, 4'b0000, 4'b0000, 32'h0000_0000, 1, 4'b0000, 0, 0, 8'h00, 4'b0000));
      vecs.push_back(mk(0, 4'b1011, 4'b0000, 32'hD000_B0A0, 1, 4'b0000, 0, 0, 8'h00, 4'b0000));
      vecs.push_back(mk(0, 4'b1011, 4'b0000, 32'hD000_B0A0, 1, 4'b0001, 1, 1, 8'hA0, 4'b0001));
      vecs.push_back(mk(0, 4'b1011, 4'b0001, 32'hD000_B0A1, 1, 4'b0001, 1, 1, 8'hA1, 4'b0001));
      vecs.push_back(mk(0, 4'b1011, 4'b0000, 32'hD000_B0A2, 1, 4'b0000, 0, 0, 8'h00, 4'b0000));
      vecs.push_back(mk(0, 4'b1011, 4'b0000, 32'hD000_B0A2, 1, 4'b0010, 1, 1, 8'hB0, 4'b0010));
      vecs.push_back(mk(0, 4'b1011, 4'b0010, 32'hD000_B1A2, 1, 4'b0010, 1, 1, 8'hB1, 4'b0010));
      vecs.push_back(mk(0, 4'b1001, 4'b0000, 32'hD000_00A2, 1, 4'b0000, 0, 0, 8'h00, 4'b0000));
      vecs.push_back(mk(0, 4'b1001, 4'b0000, 32'hD000_00A2, 1, 4'b1000, 1, 1, 8'hD0, 4'b1000));
      vecs.push_back(mk(0, 4'b1001, 4'b1000, 32'hD100_00A2, 1, 4'b1000, 1, 1, 8'hD1, 4'b1000));
      vecs.push_back(mk(0, 4'b0001, 4'b0000, 32'h0000_00A2, 1, 4'b0000, 0, 0, 8'h00, 4'b0000));
      vecs.push_back(mk(0, 4'b0001, 4'b0000, 32'h0000_00A2, 1, 4'b0001, 1, 1, 8'hA2, 4'b0001));
      vecs.push_back(mk(0, 4'b0001, 4'b0001, 32'h0000_00A3, 1, 4'b0001, 1, 1, 8'hA3, 4'b0001));
      vecs.push_back(mk(0, 4'b0000, 4'b0000, 32'h0000_0000, 1, 4'b0000, 0, 0, 8'h00, 4'b0000));

      exp_burst = '{4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000,
                    4'b0100, 4'b0100, 4'b0000, 4'b0010, 4'b0010, 4'b0000};
      exp_tmo   = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001,
                    4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b1000, 4'b0000};

      // Reset state, with requests already offered.
      Reset               = 1'b1;
      bus.ReqValid        = 4'b1111;
      bus.ReqLast         = 4'b0000;
      bus.ReqData         = 32'h1122_3344;
      bus.UartDataInReady = 1'b1;
      repeat (3) @(negedge Clock);
      #1;
      check("reset grant",  32'(bus.Grant),           32'h0);
      check("reset busy",   32'(bus.Busy),            32'h0);
      check("reset uvalid", 32'(bus.UartDataInValid), 32'h0);
      check("reset udata",  32'(bus.UartDataIn),      32'h0);
      check("reset rready", 32'(bus.ReqReady),        32'h0);

      foreach (vecs[k]) begin
         apply(vecs[k], k);
      end

      // Back-pressure: 50 stalled cycles on port 1 must not trip the 8-cycle timeout.
      clear_src();
      push(1, 8'h51, 1'b0);
      push(1, 8'h52, 1'b0);
      push(1, 8'h53, 1'b1);
      run(1'b1, 1'b0);
      check("bp arb grant", 32'(bus.Grant), 32'h0);
      run(1'b1, 1'b0);
      for (int c = 0; c < 50; c++) begin
         run(1'b0, 1'b0);
         check($sformatf("bp hold%0d", c),
               32'({bus.Grant, bus.ReqReady, bus.UartDataInValid, bus.UartDataIn}),
               32'({4'b0010, 4'b0000, 1'b1, 8'h52}));
      end
      run(1'b1, 1'b0);
      run(1'b1, 1'b0);
      run(1'b1, 1'b0);
      check("bp after grant", 32'(bus.Grant), 32'h0);
      check("bp count", 32'(nlog), 32'd3);
      check_log("bp", 0, 2'd1, 8'h51);
      check_log("bp", 1, 2'd1, 8'h52);
      check_log("bp", 2, 2'd1, 8'h53);

      // Burst cap of 4: port 1's 6-byte stream is split around port 2's message.
      clear_src();
      run(1'b0, 1'b1);
      ncyc = 0;
      for (int i = 0; i < 6; i++) begin
         push(1, 8'(8'h60 + i), (i == 5));
      end
      push(2, 8'h70, 1'b0);
      push(2, 8'h71, 1'b1);
      for (int c = 0; c < 12; c++) begin
         run(1'b1, 1'b0);
      end
      for (int c = 0; c < 12; c++) begin
         check_hist("cap", c, exp_burst[c]);
      end
      check("cap count", 32'(nlog), 32'd8);
      check_log("cap", 0, 2'd1, 8'h60);
      check_log("cap", 3, 2'd1, 8'h63);
      check_log("cap", 4, 2'd2, 8'h70);
      check_log("cap", 5, 2'd2, 8'h71);
      check_log("cap", 6, 2'd1, 8'h64);
      check_log("cap", 7, 2'd1, 8'h65);

      // Idle timeout of 8: port 0 sends one byte then goes quiet while port 3 waits.
      clear_src();
      run(1'b0, 1'b1);
      ncyc = 0;
      push(0, 8'h90, 1'b0);
      push(3, 8'h93, 1'b1);
      for (int c = 0; c < 13; c++) begin
         run(1'b1, 1'b0);
      end
      for (int c = 0; c < 13; c++) begin
         check_hist("tmo", c, exp_tmo[c]);
      end
      check("tmo count", 32'(nlog), 32'd2);
      check_log("tmo", 0, 2'd0, 8'h90);
      check_log("tmo", 1, 2'd3, 8'h93);

      // Reset during port 2's second byte, with pointer at 1 beforehand.
      clear_src();
      push(0, 8'h01, 1'b1);
      run(1'b1, 1'b0);
      run(1'b1, 1'b0);
      run(1'b1, 1'b0);
      push(2, 8'h21, 1'b0);
      push(2, 8'h22, 1'b0);
      push(2, 8'h23, 1'b1);
      run(1'b1, 1'b0);
      run(1'b1, 1'b0);
      run(1'b0, 1'b1);
      check("rst mid grant", 32'(bus.Grant), 32'h4);
      push(0, 8'h02, 1'b1);
      run(1'b1, 1'b0);
      check("rst after outs",
            32'({bus.Grant, bus.ReqReady, bus.UartDataInValid, bus.UartDataIn, bus.Busy}), 32'h0);
      run(1'b1, 1'b0);
      check("rst regrant", 32'(bus.Grant), 32'h1);
      check("rst regrant data", 32'(bus.UartDataIn), 32'h02);
      for (int c = 0; c < 4; c++) begin
         run(1'b1, 1'b0);
      end
      check("rst count", 32'(nlog), 32'd5);
      check_log("rst", 0, 2'd0, 8'h01);
      check_log("rst", 1, 2'd2, 8'h21);
      check_log("rst", 2, 2'd0, 8'h02);
      check_log("rst", 3, 2'd2, 8'h22);
      check_log("rst", 4, 2'd2, 8'h23);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
